ym_lfo_multi: RTL and testbench

YM_LFO_MULTI -- requirements
Module: ym_lfo_multi

---
 rtl/ym_lfo_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_ym_lfo_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_lfo_multi.sv
// Multi-channel LFO: a tick-driven scan visits each channel once,
// steps its prescaler/phase counter and emits AM level and PM-shifted fnum.
// Ports: MCLK/reset (async, active high), tick scan strobe, cfg_* channel
// config write, fnum_ch/fnum per-channel fnum fetch, out_valid/out_ch/
// lfo_am/fnum_lfo registered scan results, busy while scanning, overrun
// pulse when a tick lands mid-scan.
module ym_lfo_multi #(
    parameter int CHANNELS   = 4,
    parameter int CNT_WIDTH  = 7,
    parameter int FNUM_WIDTH = 11,
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  cfg_we,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic                  cfg_en,
    input  logic [2:0]            cfg_rate,
    input  logic [1:0]            cfg_wave,
    input  logic [2:0]            cfg_pms,
    output logic [CHW-1:0]        fnum_ch,
    input  logic [FNUM_WIDTH-1:0] fnum,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic [CNT_WIDTH-2:0]  lfo_am,
    output logic [FNUM_WIDTH:0]   fnum_lfo,
    output logic                  busy,
    output logic                  overrun
);

    localparam int W = CNT_WIDTH;
    localparam int F = FNUM_WIDTH;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             accept;
    logic             ovr_d;
    logic             last_ch;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;

    logic [6:0]       pre_q  [CHANNELS];
    logic [W-1:0]     cnt_q  [CHANNELS];
    logic [W-2:0]     held_q [CHANNELS];
    logic             en_q   [CHANNELS];
    logic [2:0]       rate_q [CHANNELS];
    logic [1:0]       wave_q [CHANNELS];
    logic [2:0]       pms_q  [CHANNELS];

    logic [6:0]       cur_pre;
    logic [W-1:0]     cur_cnt;
    logic [2:0]       cur_pms;
    logic [1:0]       cur_wave;
    logic [6:0]       limit;
    logic             hit;
    logic             scanning;
    logic [W-2:0]     am_d;
    logic [2:0]       pm_m;
    logic [F-2:0]     prod;
    logic [F-2:0]     offset;
    logic [2:0]       shamt;
    logic [F:0]       base;
    logic [F:0]       off_ext;
    logic [F:0]       fl_d;

    function automatic logic [6:0] pre_limit(input logic [2:0] r);
        logic [6:0] l;
        case (r)
            3'd0:    l = 7'd108;
            3'd1:    l = 7'd77;
            3'd2:    l = 7'd71;
            3'd3:    l = 7'd67;
            3'd4:    l = 7'd62;
            3'd5:    l = 7'd44;
            3'd6:    l = 7'd8;
            default: l = 7'd5;
        endcase
        return l;
    endfunction

    assign last_ch  = (ch_q == CHW'(CHANNELS - 1));
    assign scanning = (state_q == SCAN);
    assign busy     = scanning;
    assign fnum_ch  = ch_q;

    // Galois form, shifting right; 0xB400 encodes taps 16,14,13,11.
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // A tick in the final scan cycle chains straight into a new scan.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        accept  = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    ch_d    = '0;
                    accept  = 1'b1;
                end
            end
            SCAN: begin
                if (last_ch) begin
                    if (tick) begin
                        ch_d   = '0;
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ch_d  = ch_q + CHW'(1);
                    ovr_d = tick;
                end
            end
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            lfsr_q  <= 16'h0001;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            overrun <= ovr_d;
            if (accept) begin
                lfsr_q <= lfsr_next;
            end
        end
    end

    // Datapath for the channel being scanned, using pre-update counter.
    assign cur_pre  = pre_q[ch_q];
    assign cur_cnt  = cnt_q[ch_q];
    assign cur_pms  = pms_q[ch_q];
    assign cur_wave = wave_q[ch_q];
    assign limit    = pre_limit(rate_q[ch_q]);
    assign hit      = (cur_pre == limit);

    always_comb begin
        am_d = '0;
        case (cur_wave)
            2'd0:    am_d = ~(cur_cnt[W-2:0] ^ {(W-1){cur_cnt[W-1]}});
            2'd1:    am_d = ~cur_cnt[W-1:1];
            2'd2:    am_d = {(W-1){~cur_cnt[W-1]}};
            default: am_d = held_q[ch_q];
        endcase
    end

    assign pm_m    = cur_cnt[W-3:W-5] ^ {3{cur_cnt[W-2]}};
    assign prod    = {3'b000, fnum[F-1:4]} * {{(F-4){1'b0}}, pm_m};
    assign shamt   = 3'd7 - cur_pms;
    assign offset  = (cur_pms == 3'd0) ? '0 : (prod >> shamt);
    assign base    = {fnum, 1'b0};
    assign off_ext = {2'b00, offset};
    assign fl_d    = cur_cnt[W-1] ? (base - off_ext) : (base + off_ext);

    // Per-channel state; a disabling config write beats the scan update.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pre_q[i]  <= '0;
                cnt_q[i]  <= '0;
                held_q[i] <= '0;
                en_q[i]   <= 1'b0;
                rate_q[i] <= '0;
                wave_q[i] <= '0;
                pms_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && cfg_ch == CHW'(i)) begin
                    en_q[i]   <= cfg_en;
                    rate_q[i] <= cfg_rate;
                    wave_q[i] <= cfg_wave;
                    pms_q[i]  <= cfg_pms;
                end
                if (cfg_we && cfg_ch == CHW'(i) && !cfg_en) begin
                    pre_q[i] <= '0;
                    cnt_q[i] <= '0;
                end else if (scanning && ch_q == CHW'(i)) begin
                    if (!en_q[i]) begin
                        pre_q[i] <= '0;
                        cnt_q[i] <= '0;
                    end else if (hit) begin
                        pre_q[i] <= '0;
                        cnt_q[i] <= cnt_q[i] + W'(1);
                    end else begin
                        pre_q[i] <= pre_q[i] + 7'd1;
                    end
                end
                if (scanning && ch_q == CHW'(i) && en_q[i] && hit
                    && wave_q[i] == 2'd3) begin
                    held_q[i] <= lfsr_q[W-2:0];
                end
            end
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            lfo_am    <= '0;
            fnum_lfo  <= '0;
        end else begin
            out_valid <= scanning;
            if (scanning) begin
                out_ch   <= ch_q;
                lfo_am   <= am_d;
                fnum_lfo <= fl_d;
            end
        end
    end

endmodule

// File: tb/tb_ym_lfo_multi.sv
// Self-checking bench for ym_lfo_multi: directed cases plus random
// ticks/config writes compared every cycle against a behavioural model.
module tb_ym_lfo_multi;

    localparam int CH = 4;
    localparam int W  = 7;
    localparam int F  = 11;
    localparam int HALF = 1 << (W - 1);
    localparam int AMAX = HALF - 1;
    localparam int PL[8] = '{108, 77, 71, 67, 62, 44, 8, 5};

    logic        MCLK = 0;
    logic        reset;
    logic        tick = 0;
    logic        cfg_we = 0;
    logic [1:0]  cfg_ch = 0;
    logic        cfg_en = 0;
    logic [2:0]  cfg_rate = 0;
    logic [1:0]  cfg_wave = 0;
    logic [2:0]  cfg_pms = 0;
    logic [1:0]  fnum_ch;
    logic [10:0] fnum;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [5:0]  lfo_am;
    logic [11:0] fnum_lfo;
    logic        busy;
    logic        overrun;

    logic [10:0] fnum_tab [CH];
    assign fnum = fnum_tab[fnum_ch];

    ym_lfo_multi #(.CHANNELS(CH), .CNT_WIDTH(W), .FNUM_WIDTH(F)) dut (
        .MCLK(MCLK), .reset(reset), .tick(tick),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_rate(cfg_rate), .cfg_wave(cfg_wave), .cfg_pms(cfg_pms),
        .fnum_ch(fnum_ch), .fnum(fnum),
        .out_valid(out_valid), .out_ch(out_ch), .lfo_am(lfo_am),
        .fnum_lfo(fnum_lfo), .busy(busy), .overrun(overrun)
    );

    always #5 MCLK = ~MCLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pre [CH];
    int m_cnt [CH];
    int m_held[CH];
    int m_en  [CH];
    int m_rate[CH];
    int m_wave[CH];
    int m_pms [CH];
    int m_lfsr;
    bit m_scan;
    int m_ch;
    bit exp_valid, exp_ovr;
    int exp_ch, exp_am, exp_fl;

    function automatic int lfsr_adv(input int l);
        int r;
        r = l >> 1;
        if (l & 1) r = r ^ 'hB400;
        return r;
    endfunction

    function automatic int am_of(input int wave, input int v, input int held);
        case (wave)
            0:       return (v < HALF) ? AMAX - v : v - HALF;
            1:       return AMAX - v / 2;
            2:       return (v < HALF) ? AMAX : 0;
            default: return held;
        endcase
    endfunction

    function automatic int fl_of(input int f, input int pms, input int v);
        int q, off, base, md;
        q = (v >> (W - 5)) & 7;
        if (((v >> (W - 2)) & 1) != 0) q = 7 - q;
        off = (pms == 0) ? 0 : (((f >> 4) * q) >> (7 - pms));
        base = 2 * f;
        md = 1 << (F + 1);
        if (v >= HALF) return (base - off + md) % md;
        return (base + off) % md;
    endfunction

    int c, v;

    always @(posedge MCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_pre[i] = 0; m_cnt[i] = 0; m_held[i] = 0;
                m_en[i] = 0; m_rate[i] = 0; m_wave[i] = 0; m_pms[i] = 0;
            end
            m_lfsr = 1;
            m_scan = 0;
            m_ch = 0;
            exp_valid = 0;
            exp_ovr = 0;
            exp_ch = 0;
            exp_am = 0;
            exp_fl = 0;
        end else begin
            exp_ovr = m_scan && tick && (m_ch != CH - 1);
            exp_valid = m_scan;
            if (m_scan) begin
                c = m_ch;
                v = m_cnt[c];
                exp_ch = c;
                exp_am = am_of(m_wave[c], v, m_held[c]);
                exp_fl = fl_of(int'(fnum_tab[c]), m_pms[c], v);
                if (m_en[c] == 0) begin
                    m_pre[c] = 0;
                    m_cnt[c] = 0;
                end else if (m_pre[c] == PL[m_rate[c]]) begin
                    m_pre[c] = 0;
                    m_cnt[c] = (v + 1) % (1 << W);
                    if (m_wave[c] == 3) m_held[c] = m_lfsr % HALF;
                end else begin
                    m_pre[c] = m_pre[c] + 1;
                end
            end
            if (!m_scan) begin
                if (tick) begin
                    m_scan = 1;
                    m_ch = 0;
                    m_lfsr = lfsr_adv(m_lfsr);
                end
            end else if (m_ch == CH - 1) begin
                if (tick) begin
                    m_ch = 0;
                    m_lfsr = lfsr_adv(m_lfsr);
                end else begin
                    m_scan = 0;
                end
            end else begin
                m_ch = m_ch + 1;
            end
            if (cfg_we) begin
                c = int'(cfg_ch);
                m_en[c] = int'(cfg_en);
                m_rate[c] = int'(cfg_rate);
                m_wave[c] = int'(cfg_wave);
                m_pms[c] = int'(cfg_pms);
                if (!cfg_en) begin
                    m_pre[c] = 0;
                    m_cnt[c] = 0;
                end
            end
        end
    end

    // ---------------- compare / monitor ----------------
    int oq[$];
    int sq[$];
    int last_am[CH];
    int last_fl[CH];
    int n_ovr = 0;

    always @(negedge MCLK) begin
        cyc++;
        chk("busy", int'(busy), int'(m_scan));
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("overrun", int'(overrun), int'(exp_ovr));
        if (m_scan) chk("fnum_ch", int'(fnum_ch), m_ch);
        if (exp_valid) begin
            chk("out_ch", int'(out_ch), exp_ch);
            chk("lfo_am", int'(lfo_am), exp_am);
            chk("fnum_lfo", int'(fnum_lfo), exp_fl);
        end
        if (out_valid && !reset) begin
            oq.push_back(int'(out_ch));
            sq.push_back(cyc);
            last_am[out_ch] = int'(lfo_am);
            last_fl[out_ch] = int'(fnum_lfo);
        end
        if (overrun && !reset) n_ovr++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge MCLK);
        reset = 1; tick = 0; cfg_we = 0;
        repeat (2) @(negedge MCLK);
        reset = 0;
    endtask

    task automatic cfg(input int ch, input int en, input int rate,
                       input int wave, input int pms);
        @(negedge MCLK);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_en = 1'(en);
        cfg_rate = 3'(rate); cfg_wave = 2'(wave); cfg_pms = 3'(pms);
        @(negedge MCLK);
        cfg_we = 0;
    endtask

    task automatic do_tick();
        oq.delete();
        sq.delete();
        @(negedge MCLK);
        tick = 1;
        @(negedge MCLK);
        tick = 0;
        repeat (CH + 1) @(negedge MCLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic check_scan(input string nm);
        chk({nm, "_pulses"}, oq.size(), CH);
        for (int i = 0; i < CH; i++) begin
            if (i < oq.size()) begin
                chk({nm, "_order"}, oq[i], i);
                chk({nm, "_consec"}, sq[i] - sq[0], i);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < CH; i++) fnum_tab[i] = 11'h123;
        reset = 1;
        repeat (3) @(negedge MCLK);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_lfo_am", int'(lfo_am), 0);
        chk("rst_fnum_lfo", int'(fnum_lfo), 0);
        reset = 0;

        // All channels disabled, fnum 0x123.
        do_tick();
        check_scan("dis_scan");
        for (int i = 0; i < CH; i++) begin
            chk("dis_am", last_am[i], 'h3F);
            chk("dis_fl", last_fl[i], 'h246);
        end

        // Fastest rate triangle: first counter step after 6 ticks.
        cfg(0, 1, 7, 0, 0);
        ticks(6);
        chk("rate7_t6_am", last_am[0], 'h3F);
        do_tick();
        chk("rate7_t7_am", last_am[0], 'h3E);

        // PM depth 7 at cnt=16.
        do_reset();
        fnum_tab[0] = 11'h400;
        cfg(0, 1, 7, 0, 7);
        ticks(96);
        do_tick();
        chk("pm7_am", last_am[0], 'h2F);
        chk("pm7_fl", last_fl[0], 'h900);

        do_reset();
        cfg(0, 1, 7, 0, 0);
        ticks(96);
        do_tick();
        chk("pm0_fl", last_fl[0], 'h800);

        // Tick landing in the second scan cycle.
        n_ovr = 0;
        oq.delete();
        sq.delete();
        @(negedge MCLK); tick = 1;
        @(negedge MCLK); tick = 0;
        @(negedge MCLK); tick = 1;
        @(negedge MCLK); tick = 0;
        repeat (CH + 2) @(negedge MCLK);
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_out_pulses", oq.size(), CH);

        // Disable a running channel during its own scan cycle.
        fnum_tab[1] = 11'h2A5;
        cfg(1, 1, 6, 0, 5);
        ticks(20);
        oq.delete();
        sq.delete();
        @(negedge MCLK); tick = 1;
        @(negedge MCLK); tick = 0;
        @(negedge MCLK);
        cfg_we = 1; cfg_ch = 2'd1; cfg_en = 0;
        cfg_rate = 3'd6; cfg_wave = 2'd0; cfg_pms = 3'd5;
        @(negedge MCLK); cfg_we = 0;
        repeat (CH) @(negedge MCLK);
        do_tick();
        chk("clr_am", last_am[1], 'h3F);
        chk("clr_fl", last_fl[1], 'h54A);

        // Reset in the middle of a scan.
        @(negedge MCLK); tick = 1;
        @(negedge MCLK); tick = 0;
        @(negedge MCLK);
        @(posedge MCLK);
        #2 reset = 1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge MCLK);
        @(negedge MCLK);
        reset = 0;
        do_tick();
        check_scan("post_rst");

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge MCLK);
            tick = ($urandom_range(0, 3) == 0);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_ch = 2'($urandom_range(0, CH - 1));
            cfg_en = ($urandom_range(0, 4) != 0);
            cfg_rate = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(6, 7))
                                                   : 3'($urandom_range(0, 7));
            cfg_wave = 2'($urandom_range(0, 3));
            cfg_pms = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0)
                fnum_tab[$urandom_range(0, CH - 1)] = 11'($urandom);
        end
        @(negedge MCLK);
        tick = 0;
        cfg_we = 0;
        repeat (CH + 2) @(negedge MCLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
